// File: rtl/pulse_period_meter.sv
// Measures the clock count between rising edges of pulse_in, reports each period with a
// one-cycle strobe, and flags lock/overflow. Define PERIOD_METER_SYNC_EN to add a 2-flop input synchronizer.
module pulse_period_meter #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             overflow
);

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    localparam logic [WIDTH-1:0] MAX      = '1;
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       matchCnt_q, matchCnt_d;
    logic             havePrev_q, havePrev_d;
    logic             pulseDly_q;
    logic             pulseSrc;
    logic             rise;
    logic [3:0]       matchNext;

`ifdef PERIOD_METER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pulse_in;
            sync2_q <= sync1_q;
        end
    end

    assign pulseSrc = sync2_q;
`else
    assign pulseSrc = pulse_in;
`endif

    assign rise = pulseSrc & ~pulseDly_q;

    // havePrev_q marks that the period register holds a measurement that a new one may match
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        overflow_d = overflow_q;
        matchCnt_d = matchCnt_q;
        havePrev_d = havePrev_q;
        matchNext  = 4'd0;
        case (state_q)
            IDLE: begin
                counter_d = '0;
                if (rise) begin
                    state_d   = MEAS;
                    counter_d = {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            MEAS: begin
                if (rise) begin
                    counter_d  = {{(WIDTH-1){1'b0}}, 1'b1};
                    overflow_d = 1'b0;
                    if (counter_q != MAX) begin
                        period_d = counter_q;
                        valid_d  = 1'b1;
                        if (havePrev_q && (counter_q == period_q)) begin
                            matchNext = (matchCnt_q >= LOCK_MAX) ? LOCK_MAX : matchCnt_q + 4'd1;
                        end
                        matchCnt_d = matchNext;
                        locked_d   = (matchNext == LOCK_MAX);
                        havePrev_d = 1'b1;
                    end else begin
                        matchCnt_d = 4'd0;
                        locked_d   = 1'b0;
                        havePrev_d = 1'b0;
                    end
                end else if (counter_q == MAX) begin
                    overflow_d = 1'b1;
                    locked_d   = 1'b0;
                    matchCnt_d = 4'd0;
                    havePrev_d = 1'b0;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
            matchCnt_q <= 4'd0;
            havePrev_q <= 1'b0;
            pulseDly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            overflow_q <= overflow_d;
            matchCnt_q <= matchCnt_d;
            havePrev_q <= havePrev_d;
            pulseDly_q <= pulseSrc;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: expected periods are queued as edges are driven
// and checked when period_valid fires. Honours PERIOD_METER_SYNC_EN for the latency shift.
module tb_pulse_period_meter;

    localparam int WIDTH = 8;
    localparam int LOCK  = 3;
    localparam int MAXV  = 255;
`ifdef PERIOD_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             pulse_in = 1'b0;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             overflow;

    pulse_period_meter #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   per;
        int   cycle;
        logic lck;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    bit haveEdge  = 1'b0;
    int lastE     = 0;
    bit prevValid = 1'b0;
    int lastPer   = 0;
    int match     = 0;
    bit level     = 1'b0;
    int invalidE  = -1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic resetModel();
        haveEdge  = 1'b0;
        prevValid = 1'b0;
        match     = 0;
        level     = 1'b0;
        invalidE  = -1;
        sb.delete();
    endtask

    // Called while driving a new rising level; E is the internal edge index the DUT sees it at
    task automatic modelEdge();
        int E;
        int gap;
        E = cyc + 1 + LAT;
        if (haveEdge) begin
            gap = E - lastE;
            if (gap >= MAXV) begin
                invalidE  = E;
                prevValid = 1'b0;
                match     = 0;
            end else begin
                if (prevValid && gap == lastPer)
                    match = (match + 1 > LOCK) ? LOCK : match + 1;
                else
                    match = 0;
                lastPer   = gap;
                prevValid = 1'b1;
                sb.push_back('{gap, E, (match == LOCK)});
            end
        end
        haveEdge = 1'b1;
        lastE    = E;
    endtask

    task automatic driveCycle(input logic v);
        @(negedge clk);
        pulse_in = v;
        if (v && !level) modelEdge();
        level = v;
    endtask

    task automatic applyStimulus(input int highCycles, input int lowCycles, input int reps);
        for (int r = 0; r < reps; r++) begin
            repeat (highCycles) driveCycle(1'b1);
            repeat (lowCycles) driveCycle(1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (period_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("valid_cycle", cyc, e.cycle);
                    checkOutput("period", {24'd0, period}, e.per);
                    checkOutput("locked_at_valid", {31'd0, locked}, {31'd0, e.lck});
                end
            end
            if (haveEdge && (cyc - lastE) == MAXV - 1)
                checkOutput("ovf_early", {31'd0, overflow}, 32'd0);
            if (haveEdge && (cyc - lastE) == MAXV) begin
                checkOutput("ovf_rise", {31'd0, overflow}, 32'd1);
                checkOutput("ovf_unlock", {31'd0, locked}, 32'd0);
            end
            if (cyc == invalidE)
                checkOutput("ovf_clear", {31'd0, overflow}, 32'd0);
        end
    end

    initial begin
        rst_n    = 1'b0;
        pulse_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pulse_in = ~pulse_in;
            checkOutput("reset_outs", {21'd0, period, period_valid, locked, overflow}, 32'd0);
        end
        @(negedge clk);
        pulse_in = 1'b0;
        resetModel();
        rst_n = 1'b1;

        repeat (100) driveCycle(1'b0);
        checkOutput("idle_ovf", {31'd0, overflow}, 32'd0);

        applyStimulus(1, 4, 6);
        checkOutput("lock_p5", {31'd0, locked}, 32'd1);

        applyStimulus(1, 6, 5);
        checkOutput("relock_p7", {31'd0, locked}, 32'd1);

        applyStimulus(1, 300, 1);
        applyStimulus(1, 9, 4);
        checkOutput("post_gap_ovf", {31'd0, overflow}, 32'd0);

        applyStimulus(10, 10, 4);

        driveCycle(1'b1);
        repeat (3) driveCycle(1'b0);
        checkOutput("pre_reset_queue", sb.size(), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_period", {24'd0, period}, 32'd0);
        checkOutput("async_valid", {31'd0, period_valid}, 32'd0);
        checkOutput("async_locked", {31'd0, locked}, 32'd0);
        checkOutput("async_ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        resetModel();
        pulse_in = 1'b0;
        rst_n    = 1'b1;

        applyStimulus(1, 6, 3);
        repeat (6) driveCycle(1'b0);
        checkOutput("drain_queue", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
